// File: rtl/cu_read_command_issue_control_pkg.sv
// Shared types and default sizing for the read command issue controller.
// The command queue entry, response and status layouts are defined once here.
package cu_pkg;

   localparam int CU_FIFO_DEPTH      = 16;
   localparam int CU_MAX_OUTSTANDING = 32;
   localparam int CU_ALFULL_MARGIN   = 4;
   localparam int CMD_PAYLOAD_W      = 32;
   localparam int RSP_TAG_W          = 16;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_STALL = 2'd2,
      ST_DRAIN = 2'd3
   } issue_state_e;

   typedef struct packed {
      logic                     valid;
      logic [CMD_PAYLOAD_W-1:0] payload;
   } CommandBufferLine;

   typedef struct packed {
      logic                 valid;
      logic [RSP_TAG_W-1:0] tag;
   } ResponseBufferLine;

   typedef struct packed {
      logic alfull;
      logic full;
      logic empty;
   } BufferStatus;

endpackage

// File: rtl/cu_read_command_issue_control_fifo.sv
// Single-clock command queue with registered empty/full/almost-full flags.
// Pointers carry one extra wrap bit so a full queue differs from an empty one.
module cu_command_sync_fifo
   import cu_pkg::*;
#(
   parameter int DEPTH         = CU_FIFO_DEPTH,
   parameter int ALFULL_MARGIN = CU_ALFULL_MARGIN,
   parameter int WIDTH         = CMD_PAYLOAD_W
) (
   input  logic             clock,
   input  logic             rst_in,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head_data,
   output BufferStatus      status
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT   = (AW+1)'(DEPTH);
   localparam logic [AW:0] ALFULL_CNT = (AW+1)'(DEPTH - ALFULL_MARGIN);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr, rd_ptr;
   logic [AW:0]      wr_ptr_next, rd_ptr_next, count_next;
   logic             wr_en, rd_en;

   // A pop in the same cycle frees the slot a push to a full queue needs.
   assign wr_en = push & (~status.full | pop);
   assign rd_en = pop & ~status.empty;

   assign wr_ptr_next = wr_ptr + {{AW{1'b0}}, wr_en};
   assign rd_ptr_next = rd_ptr + {{AW{1'b0}}, rd_en};
   assign count_next  = wr_ptr_next - rd_ptr_next;

   assign head_data = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clock) begin
      if (wr_en) begin
         mem[wr_ptr[AW-1:0]] <= push_data;
      end
   end

   always_ff @(posedge clock) begin
      if (rst_in) begin
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         status.empty  <= 1'b1;
         status.full   <= 1'b0;
         status.alfull <= 1'b0;
      end else begin
         wr_ptr        <= wr_ptr_next;
         rd_ptr        <= rd_ptr_next;
         status.empty  <= (count_next == '0);
         status.full   <= (count_next == FULL_CNT);
         status.alfull <= (count_next >= ALFULL_CNT);
      end
   end

endmodule

// File: rtl/cu_read_command_issue_control.sv
// Queues filtered read commands and issues them to the CAPI command buffer,
// capping in-flight reads and supporting a flush that drains everything.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | queue empty or not yet enabled; nothing issued
// ST_ISSUE | popping one command per cycle while downstream and cap allow
// ST_STALL | commands waiting but downstream not ready or cap reached
// ST_DRAIN | flush: no pushes, keep issuing, wait for all responses
module cu_read_command_issue_control
   import cu_pkg::*;
#(
   parameter int FIFO_DEPTH      = CU_FIFO_DEPTH,
   parameter int MAX_OUTSTANDING = CU_MAX_OUTSTANDING,
   parameter int ALFULL_MARGIN   = CU_ALFULL_MARGIN
) (
   input  logic                               clock,
   input  logic                               rst_in,
   input  logic                               enabled_in,
   input  logic                               flush_in,
   input  CommandBufferLine                   read_command_in,
   input  ResponseBufferLine                  read_response_in,
   input  logic                               command_buffer_ready_in,
   output CommandBufferLine                   read_command_out,
   output BufferStatus                        read_buffer_status_out,
   output logic [$clog2(MAX_OUTSTANDING):0]   outstanding_count_out,
   output logic                               drained_out,
   output logic [1:0]                         error_out
);

   localparam int OW = $clog2(MAX_OUTSTANDING) + 1;
   localparam logic [OW-1:0] OUT_CAP = OW'(MAX_OUTSTANDING);

   issue_state_e            state, state_next;
   logic [CMD_PAYLOAD_W-1:0] head_data;
   logic                    push_req, pop, issue_ok, fifo_empty, fifo_full;
   logic                    resp_valid, no_outstanding, drain_done;
   logic                    resp_tag_unused;

   assign fifo_empty      = read_buffer_status_out.empty;
   assign fifo_full       = read_buffer_status_out.full;
   assign resp_valid      = read_response_in.valid;
   assign resp_tag_unused = ^read_response_in.tag;
   assign no_outstanding  = (outstanding_count_out == '0);
   assign issue_ok        = command_buffer_ready_in & (outstanding_count_out < OUT_CAP);
   assign drain_done      = fifo_empty & no_outstanding;
   assign push_req        = read_command_in.valid & enabled_in & ~flush_in
                            & (state != ST_DRAIN);

   cu_command_sync_fifo #(
      .DEPTH         (FIFO_DEPTH),
      .ALFULL_MARGIN (ALFULL_MARGIN),
      .WIDTH         (CMD_PAYLOAD_W)
   ) u_fifo (
      .clock     (clock),
      .rst_in    (rst_in),
      .push      (push_req),
      .push_data (read_command_in.payload),
      .pop       (pop),
      .head_data (head_data),
      .status    (read_buffer_status_out)
   );

   always_ff @(posedge clock) begin
      if (rst_in) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      unique case (state)
         ST_IDLE: begin
            if (flush_in)                       state_next = ST_DRAIN;
            else if (enabled_in & ~fifo_empty)  state_next = ST_ISSUE;
         end
         ST_ISSUE: begin
            if (flush_in)                       state_next = ST_DRAIN;
            else if (enabled_in) begin
               if (fifo_empty & ~push_req)      state_next = ST_IDLE;
               else if (~issue_ok)              state_next = ST_STALL;
            end
         end
         ST_STALL: begin
            if (flush_in)                       state_next = ST_DRAIN;
            else if (enabled_in) begin
               if (fifo_empty & ~push_req)      state_next = ST_IDLE;
               else if (issue_ok)               state_next = ST_ISSUE;
            end
         end
         ST_DRAIN: begin
            if (drain_done)                     state_next = ST_IDLE;
         end
         default:                               state_next = ST_IDLE;
      endcase
   end

   // STALL pops on the first cycle the conditions recover, so no bubble is lost.
   always_comb begin
      pop         = 1'b0;
      drained_out = 1'b0;
      if (state != ST_IDLE) begin
         pop = enabled_in & issue_ok & ~fifo_empty;
      end
      if (state == ST_DRAIN) begin
         drained_out = drain_done;
      end
   end

   always_ff @(posedge clock) begin
      if (rst_in) begin
         outstanding_count_out <= '0;
         error_out             <= 2'b00;
         read_command_out      <= '0;
      end else begin
         if (pop & ~resp_valid) begin
            outstanding_count_out <= outstanding_count_out + OW'(1);
         end else if (~pop & resp_valid & ~no_outstanding) begin
            outstanding_count_out <= outstanding_count_out - OW'(1);
         end
         if (push_req & fifo_full & ~pop) begin
            error_out[0] <= 1'b1;
         end
         if (resp_valid & ~pop & no_outstanding) begin
            error_out[1] <= 1'b1;
         end
         read_command_out.valid <= pop;
         if (pop) begin
            read_command_out.payload <= head_data;
         end
      end
   end

endmodule

// File: tb/tb_cu_read_command_issue_control.sv
// Directed scenarios with random payloads; issued payloads are checked against
// a push-order queue and counts against values derived from the issue rules.
module tb_cu_read_command_issue_control;
   import cu_pkg::*;

   logic              clock;
   logic              rst_in;
   logic              enabled_in;
   logic              flush_in;
   CommandBufferLine  read_command_in;
   ResponseBufferLine read_response_in;
   logic              command_buffer_ready_in;
   CommandBufferLine  read_command_out;
   BufferStatus       read_buffer_status_out;
   logic [5:0]        outstanding_count_out;
   logic              drained_out;
   logic [1:0]        error_out;

   int tests = 0;
   int fails = 0;
   int issued, drained_seen, cyc, first_cyc, last_cyc;
   logic [31:0] exp_q [$];

   cu_read_command_issue_control #(
      .FIFO_DEPTH      (16),
      .MAX_OUTSTANDING (32),
      .ALFULL_MARGIN   (4)
   ) dut (
      .clock                   (clock),
      .rst_in                  (rst_in),
      .enabled_in              (enabled_in),
      .flush_in                (flush_in),
      .read_command_in         (read_command_in),
      .read_response_in        (read_response_in),
      .command_buffer_ready_in (command_buffer_ready_in),
      .read_command_out        (read_command_out),
      .read_buffer_status_out  (read_buffer_status_out),
      .outstanding_count_out   (outstanding_count_out),
      .drained_out             (drained_out),
      .error_out               (error_out)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance one cycle, sample 1ns after the edge, score any issued command.
   task automatic tick();
      logic [31:0] want;
      @(posedge clock);
      #1;
      cyc++;
      if (read_command_out.valid === 1'b1) begin
         if (issued == 0) first_cyc = cyc;
         last_cyc = cyc;
         issued++;
         if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $error("FAIL issue_unexpected observed=%0h expected=none", read_command_out.payload);
         end else begin
            want = exp_q.pop_front();
            check("issue_payload", read_command_out.payload, want);
         end
      end
      if (drained_out === 1'b1) drained_seen++;
   endtask

   task automatic drive_push(input logic accepted);
      logic [31:0] p;
      p = $urandom;
      read_command_in.valid   = 1'b1;
      read_command_in.payload = p;
      if (accepted) exp_q.push_back(p);
   endtask

   task automatic drive_resp(input logic v);
      read_response_in.valid = v;
      read_response_in.tag   = 16'($urandom);
   endtask

   task automatic do_reset();
      rst_in = 1'b1;
      read_command_in = '0;
      read_response_in = '0;
      flush_in = 1'b0;
      tick();
      tick();
      rst_in = 1'b0;
      exp_q.delete();
      issued = 0;
      drained_seen = 0;
      first_cyc = 0;
      last_cyc = 0;
   endtask

   initial begin
      int c;
      rst_in = 1'b1;
      enabled_in = 1'b1;
      flush_in = 1'b0;
      read_command_in = '0;
      read_response_in = '0;
      command_buffer_ready_in = 1'b1;
      cyc = 0;
      issued = 0;
      drained_seen = 0;

      // Reset values, then three pushes issued back to back in order.
      do_reset();
      check("rst_status", read_buffer_status_out, 3'b001);
      check("rst_outstanding", outstanding_count_out, 0);
      check("rst_valid", read_command_out.valid, 0);
      check("rst_payload", read_command_out.payload, 0);
      check("rst_error", error_out, 0);
      check("rst_drained", drained_out, 0);
      for (int i = 0; i < 3; i++) begin
         drive_push(1'b1);
         tick();
      end
      read_command_in.valid = 1'b0;
      repeat (8) tick();
      check("burst3_issued", issued, 3);
      check("burst3_consecutive", last_cyc - first_cyc, 2);
      check("burst3_outstanding", outstanding_count_out, 3);
      check("burst3_empty", read_buffer_status_out.empty, 1);

      // Fill to 16 with downstream blocked; 17th push overflows.
      do_reset();
      command_buffer_ready_in = 1'b0;
      for (int k = 1; k <= 17; k++) begin
         drive_push(k <= 16);
         tick();
         c = (k < 16) ? k : 16;
         check("fill_full", read_buffer_status_out.full, c == 16);
         check("fill_alfull", read_buffer_status_out.alfull, c >= 12);
         check("fill_empty", read_buffer_status_out.empty, 0);
         check("fill_error", error_out, (k == 17) ? 2'b01 : 2'b00);
      end
      read_command_in.valid = 1'b0;
      command_buffer_ready_in = 1'b1;
      repeat (25) tick();
      check("fill_issued", issued, 16);
      check("fill_outstanding", outstanding_count_out, 16);
      check("fill_drained_empty", read_buffer_status_out.empty, 1);
      check("fill_error_sticky", error_out, 2'b01);

      // Outstanding cap: 32 issued then stall; one response frees exactly one.
      do_reset();
      for (int i = 0; i < 40; i++) begin
         drive_push(1'b1);
         tick();
      end
      read_command_in.valid = 1'b0;
      repeat (10) tick();
      check("cap_issued", issued, 32);
      check("cap_outstanding", outstanding_count_out, 32);
      check("cap_queue_left", read_buffer_status_out.empty, 0);
      check("cap_error", error_out, 0);
      drive_resp(1'b1);
      tick();
      drive_resp(1'b0);
      repeat (5) tick();
      check("cap_one_more", issued, 33);
      check("cap_outstanding2", outstanding_count_out, 32);

      // Simultaneous issue and response at 5, then underflow at 0.
      do_reset();
      for (int i = 0; i < 5; i++) begin
         drive_push(1'b1);
         tick();
      end
      read_command_in.valid = 1'b0;
      repeat (10) tick();
      check("five_outstanding", outstanding_count_out, 5);
      drive_push(1'b1);
      tick();
      read_command_in.valid = 1'b0;
      tick();
      check("pre_issue_valid", read_command_out.valid, 0);
      drive_resp(1'b1);
      tick();
      drive_resp(1'b0);
      check("same_cycle_valid", read_command_out.valid, 1);
      check("same_cycle_outstanding", outstanding_count_out, 5);
      for (int i = 0; i < 5; i++) begin
         drive_resp(1'b1);
         tick();
      end
      drive_resp(1'b0);
      tick();
      check("retired_outstanding", outstanding_count_out, 0);
      check("retired_error", error_out, 0);
      drive_resp(1'b1);
      tick();
      drive_resp(1'b0);
      check("underflow_error", error_out, 2'b10);
      check("underflow_outstanding", outstanding_count_out, 0);

      // Flush with 2 outstanding and 4 queued.
      do_reset();
      for (int i = 0; i < 2; i++) begin
         drive_push(1'b1);
         tick();
      end
      read_command_in.valid = 1'b0;
      repeat (8) tick();
      check("flush_pre_outstanding", outstanding_count_out, 2);
      command_buffer_ready_in = 1'b0;
      for (int i = 0; i < 4; i++) begin
         drive_push(1'b1);
         tick();
      end
      read_command_in.valid = 1'b0;
      repeat (2) tick();
      flush_in = 1'b1;
      command_buffer_ready_in = 1'b1;
      for (int i = 0; i < 6; i++) begin
         drive_push(1'b0);
         tick();
      end
      read_command_in.valid = 1'b0;
      flush_in = 1'b0;
      tick();
      check("flush_issued", issued, 6);
      check("flush_outstanding", outstanding_count_out, 6);
      check("flush_empty", read_buffer_status_out.empty, 1);
      check("flush_no_early_drain", drained_seen, 0);
      check("flush_error", error_out, 0);
      for (int r = 1; r <= 6; r++) begin
         drive_resp(1'b1);
         tick();
         check("drain_pulse", drained_out, r == 6);
      end
      drive_resp(1'b0);
      repeat (3) tick();
      check("drain_pulse_count", drained_seen, 1);
      check("drain_outstanding", outstanding_count_out, 0);
      drive_push(1'b1);
      tick();
      read_command_in.valid = 1'b0;
      repeat (4) tick();
      check("post_drain_issue", issued, 7);

      // Reset in the middle of a burst of 8.
      do_reset();
      command_buffer_ready_in = 1'b0;
      for (int i = 0; i < 8; i++) begin
         drive_push(1'b1);
         tick();
      end
      read_command_in.valid = 1'b0;
      command_buffer_ready_in = 1'b1;
      tick();
      tick();
      rst_in = 1'b1;
      tick();
      exp_q.delete();
      check("midrst_empty", read_buffer_status_out.empty, 1);
      check("midrst_outstanding", outstanding_count_out, 0);
      check("midrst_valid", read_command_out.valid, 0);
      rst_in = 1'b0;
      tick();
      check("postrst_valid", read_command_out.valid, 0);
      check("postrst_empty", read_buffer_status_out.empty, 1);
      check("postrst_outstanding", outstanding_count_out, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
